// File: rtl/fu_wb_arbiter_pkg.sv
// fu_wb_arbiter_pkg: shared core sizes and functional-unit ids for the writeback arbiter
package fu_wb_arbiter_pkg;
  localparam int NUM_FU = 5;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int FU_IDW = 3;
  typedef enum logic [FU_IDW-1:0] {
    FU_ALU  = 3'd0,
    FU_MEM  = 3'd1,
    FU_MUL  = 3'd2,
    FU_DIV  = 3'd3,
    FU_JUMP = 3'd4
  } fu_id_e;
endpackage

// File: rtl/fu_wb_arbiter_if.sv
// fu_wb_arbiter_if: FU finish inputs and register-file writeback outputs of the arbiter
interface fu_wb_arbiter_if;
  import fu_wb_arbiter_pkg::*;
  logic [NUM_FU-1:0]        finish_i;
  logic [NUM_FU*XLEN-1:0]   result_i;
  logic [NUM_FU*REG_AW-1:0] rd_i;
  logic                     flush_i;
  logic                     wb_en_o;
  logic [REG_AW-1:0]        wb_rd_o;
  logic [XLEN-1:0]          wb_data_o;
  logic [FU_IDW-1:0]        wb_fu_o;
  logic [NUM_FU-1:0]        fu_release_o;
  logic [NUM_FU-1:0]        fu_busy_o;
  logic                     err_o;
  modport slave (
    input  finish_i, result_i, rd_i, flush_i,
    output wb_en_o, wb_rd_o, wb_data_o, wb_fu_o, fu_release_o, fu_busy_o, err_o
  );
  modport master (
    output finish_i, result_i, rd_i, flush_i,
    input  wb_en_o, wb_rd_o, wb_data_o, wb_fu_o, fu_release_o, fu_busy_o, err_o
  );
endinterface

// File: rtl/fu_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: per-FU result holding slots with round-robin writeback to the register file
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fu_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_FU);
  logic [NUM_FU-1:0] valid_q, valid_d, gnt, req, cap;
  logic [XLEN-1:0]   data_q [NUM_FU];
  logic [XLEN-1:0]   data_d [NUM_FU];
  logic [REG_AW-1:0] rd_q [NUM_FU];
  logic [REG_AW-1:0] rd_d [NUM_FU];
  logic [PW-1:0]     ptr_q, ptr_d, idx;
  logic              err_q, err_d, any;
  assign req = bus.flush_i ? '0 : valid_q;
  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx),
    .any_o(any)
  );
  assign bus.fu_busy_o = valid_q & ~gnt;
  assign cap = bus.flush_i ? '0 : bus.finish_i & ~bus.fu_busy_o;
  always_comb begin
    valid_d = bus.flush_i ? '0 : cap | (valid_q & ~gnt);
    for (int k = 0; k < NUM_FU; k++) begin
      data_d[k] = cap[k] ? bus.result_i[k*XLEN +: XLEN] : data_q[k];
      rd_d[k]   = cap[k] ? bus.rd_i[k*REG_AW +: REG_AW] : rd_q[k];
    end
    err_d = err_q | (~bus.flush_i & |(bus.finish_i & bus.fu_busy_o));
    ptr_d = bus.flush_i ? '0 : !any ? ptr_q : (idx == PW'(NUM_FU-1)) ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      rd_q    <= '{default: '0};
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end
  assign bus.fu_release_o = gnt;
  assign bus.wb_en_o      = any && (rd_q[idx] != '0);
  assign bus.wb_rd_o      = any ? rd_q[idx] : '0;
  assign bus.wb_data_o    = any ? data_q[idx] : '0;
  assign bus.wb_fu_o      = any ? FU_IDW'(idx) : '0;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb_fu_wb_arbiter: directed table, async reset and random checks against a slot-level model
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;
  typedef struct {
    logic [NUM_FU-1:0]        fin;
    logic [NUM_FU*XLEN-1:0]   res;
    logic [NUM_FU*REG_AW-1:0] rd;
    logic                     fl;
    logic                     en;
    logic [REG_AW-1:0]        wrd;
    logic [XLEN-1:0]          data;
    logic [FU_IDW-1:0]        fu;
    logic [NUM_FU-1:0]        rel;
    logic [NUM_FU-1:0]        busy;
    logic                     err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  fu_wb_arbiter_if bus ();
  fu_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  bit                m_valid [NUM_FU];
  logic [XLEN-1:0]   m_data  [NUM_FU];
  logic [REG_AW-1:0] m_rd    [NUM_FU];
  int                m_ptr;
  bit                m_err;
  int                g;
  logic              e_en;
  logic [REG_AW-1:0] e_rd;
  logic [XLEN-1:0]   e_data;
  logic [FU_IDW-1:0] e_fu;
  logic [NUM_FU-1:0] e_rel, e_busy;
  vec_t tbl [28];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < NUM_FU; k++) m_valid[k] = 0;
    m_ptr = 0;
    m_err = 0;
  endtask
  task automatic model_expect(input logic fl);
    int order [$];
    g = -1;
    for (int i = m_ptr; i < NUM_FU; i++) order.push_back(i);
    for (int i = 0; i < m_ptr; i++) order.push_back(i);
    if (!fl) foreach (order[i]) if (g < 0 && m_valid[order[i]]) g = order[i];
    e_en   = (g >= 0) && (m_rd[g] != 0);
    e_rd   = (g >= 0) ? m_rd[g] : '0;
    e_data = (g >= 0) ? m_data[g] : '0;
    e_fu   = (g >= 0) ? FU_IDW'(g) : '0;
    e_rel  = (g >= 0) ? NUM_FU'(1) << g : '0;
    for (int k = 0; k < NUM_FU; k++) e_busy[k] = m_valid[k] && (g != k);
  endtask
  task automatic apply(input logic [NUM_FU-1:0] fin, input logic [NUM_FU*XLEN-1:0] res,
                       input logic [NUM_FU*REG_AW-1:0] rd, input logic fl);
    bus.finish_i = fin;
    bus.result_i = res;
    bus.rd_i     = rd;
    bus.flush_i  = fl;
    #2;
  endtask
  task automatic verify_model();
    model_expect(bus.flush_i);
    chk("m_wb_en", bus.wb_en_o, e_en);
    chk("m_wb_rd", bus.wb_rd_o, e_rd);
    chk("m_wb_data", bus.wb_data_o, e_data);
    chk("m_wb_fu", bus.wb_fu_o, e_fu);
    chk("m_release", bus.fu_release_o, e_rel);
    chk("m_busy", bus.fu_busy_o, e_busy);
    chk("m_err", bus.err_o, m_err);
  endtask
  task automatic advance();
    model_expect(bus.flush_i);
    if (bus.flush_i) begin
      for (int k = 0; k < NUM_FU; k++) m_valid[k] = 0;
      m_ptr = 0;
    end else begin
      if (g >= 0) begin
        m_valid[g] = 0;
        m_ptr = (g + 1) % NUM_FU;
      end
      for (int k = 0; k < NUM_FU; k++) if (bus.finish_i[k]) begin
        if (e_busy[k]) m_err = 1;
        else begin
          m_valid[k] = 1;
          m_data[k]  = bus.result_i[k*XLEN +: XLEN];
          m_rd[k]    = bus.rd_i[k*REG_AW +: REG_AW];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic [4:0] fin, input logic [31:0] base,
                              input logic [4:0] r0, r1, r2, r3, r4, input logic fl,
                              input logic en, input logic [4:0] wrd, input logic [31:0] data,
                              input logic [2:0] fu, input logic [4:0] rel, busy, input logic err);
    vec_t v;
    v.fin = fin;
    for (int k = 0; k < NUM_FU; k++) v.res[k*XLEN +: XLEN] = base + 32'(k);
    v.rd = {r4, r3, r2, r1, r0};
    v.fl = fl; v.en = en; v.wrd = wrd; v.data = data; v.fu = fu;
    v.rel = rel; v.busy = busy; v.err = err;
    return v;
  endfunction
  initial begin
    logic [NUM_FU-1:0]        fin;
    logic [NUM_FU*XLEN-1:0]   res;
    logic [NUM_FU*REG_AW-1:0] rd;
    logic                     fl;
    tbl[0]  = mk(5'b00010, 32'hDEADBEEE, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[1]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 1, 5'b00010, 5'b00000, 0);
    tbl[2]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[3]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[4]  = mk(5'b11111, 32'h100, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[5]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0, 5'b00001, 5'b11110, 0);
    tbl[6]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h101, 1, 5'b00010, 5'b11100, 0);
    tbl[7]  = mk(5'b00100, 32'h200, 0, 0, 9, 0, 0, 0, 1, 3, 32'h102, 2, 5'b00100, 5'b11000, 0);
    tbl[8]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h103, 3, 5'b01000, 5'b10100, 0);
    tbl[9]  = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h104, 4, 5'b10000, 5'b00100, 0);
    tbl[10] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h202, 2, 5'b00100, 5'b00000, 0);
    tbl[11] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[12] = mk(5'b10001, 32'h300, 10, 0, 0, 0, 11, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[13] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'h300, 0, 5'b00001, 5'b10000, 0);
    tbl[14] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'h304, 4, 5'b10000, 5'b00000, 0);
    tbl[15] = mk(5'b01001, 32'h400, 12, 0, 0, 13, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    tbl[16] = mk(5'b01000, 32'h500, 0, 0, 0, 14, 0, 0, 1, 12, 32'h400, 0, 5'b00001, 5'b01000, 0);
    tbl[17] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'h403, 3, 5'b01000, 5'b00000, 1);
    tbl[18] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    tbl[19] = mk(5'b00001, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    tbl[20] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600, 0, 5'b00001, 5'b00000, 1);
    tbl[21] = mk(5'b00111, 32'h700, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    tbl[22] = mk(5'b00010, 32'h800, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00111, 1);
    tbl[23] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    tbl[24] = mk(5'b10001, 32'h900, 6, 0, 0, 0, 7, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    tbl[25] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h900, 0, 5'b00001, 5'b10000, 1);
    tbl[26] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h904, 4, 5'b10000, 5'b00000, 1);
    tbl[27] = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1);
    model_reset();
    bus.finish_i = '1;
    bus.result_i = '1;
    bus.rd_i     = '1;
    bus.flush_i  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_wb_en", bus.wb_en_o, 0);
    chk("rst_outs", {bus.wb_rd_o, bus.wb_data_o, bus.wb_fu_o}, 0);
    chk("rst_release", bus.fu_release_o, 0);
    chk("rst_busy", bus.fu_busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply('0, '0, '0, 1'b0);
    verify_model();
    advance();
    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].fin, tbl[i].res, tbl[i].rd, tbl[i].fl);
      chk($sformatf("t%0d_wb_en", i), bus.wb_en_o, tbl[i].en);
      chk($sformatf("t%0d_wb_rd", i), bus.wb_rd_o, tbl[i].wrd);
      chk($sformatf("t%0d_wb_data", i), bus.wb_data_o, tbl[i].data);
      chk($sformatf("t%0d_wb_fu", i), bus.wb_fu_o, tbl[i].fu);
      chk($sformatf("t%0d_release", i), bus.fu_release_o, tbl[i].rel);
      chk($sformatf("t%0d_busy", i), bus.fu_busy_o, tbl[i].busy);
      chk($sformatf("t%0d_err", i), bus.err_o, tbl[i].err);
      verify_model();
      advance();
    end
    apply(5'b11111, {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
    verify_model();
    advance();
    apply('0, '0, '0, 1'b0);
    verify_model();
    chk("pre_async_wb_en", bus.wb_en_o, 1);
    rst_n = 1'b0;
    #1;
    chk("async_wb_en", bus.wb_en_o, 0);
    chk("async_outs", {bus.wb_rd_o, bus.wb_data_o, bus.wb_fu_o}, 0);
    chk("async_release", bus.fu_release_o, 0);
    chk("async_busy", bus.fu_busy_o, 0);
    chk("async_err", bus.err_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      fl = ($urandom_range(0, 31) == 0);
      model_expect(fl);
      fin = NUM_FU'($urandom);
      if ($urandom_range(0, 15) != 0) fin &= ~e_busy;
      for (int k = 0; k < NUM_FU; k++) begin
        res[k*XLEN +: XLEN] = $urandom;
        rd[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 31));
      end
      apply(fin, res, rd, fl);
      verify_model();
      advance();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
